// File: rtl/openfc_pkg.sv
// openfc_pkg: shared decoupler state type and width helper
package openfc_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, FROZEN, RELEASE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/stream_idle_mon.sv
// stream_idle_mon: flags a stream idle after IdleCycles consecutive VALID-low cycles
module stream_idle_mon
  import openfc_pkg::*;
#(
  parameter int IdleCycles = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic VALID,
  output logic IDLE
);
  localparam int W = clog2(IdleCycles + 1);
  localparam logic [W-1:0] MAX = W'(IdleCycles);
  logic [W-1:0] cnt_q, cnt_d;
  // saturating count of VALID-low cycles, cleared by any flit
  always_comb cnt_d = VALID ? '0 : (cnt_q == MAX ? cnt_q : cnt_q + 1'b1);
  // idle counter register
  always_ff @(posedge CLK) cnt_q <= RST ? '0 : cnt_d;
  assign IDLE = cnt_q == MAX;
endmodule

// File: rtl/pr_decoupler.sv
// pr_decoupler: drain, isolate and reset-sequence a reconfigurable PE region
module pr_decoupler
  import openfc_pkg::*;
#(
  parameter int NumCh        = 2,
  parameter int Width        = 64,
  parameter int IdleCycles   = 4,
  parameter int DrainTimeout = 4096,
  parameter int RstCycles    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FREEZE_REQ,
  output logic                   FREEZE_ACK,
  output logic                   PE_RST,
  output logic                   DRAIN_TIMEOUT,
  input  logic [NumCh*Width-1:0] UP_D,
  input  logic [NumCh-1:0]       UP_D_VALID,
  output logic [NumCh-1:0]       UP_D_BP,
  output logic [NumCh*Width-1:0] DN_D,
  output logic [NumCh-1:0]       DN_D_VALID,
  input  logic [NumCh-1:0]       DN_D_BP,
  input  logic [NumCh*Width-1:0] DN_Q,
  input  logic [NumCh-1:0]       DN_Q_VALID,
  output logic [NumCh-1:0]       DN_Q_BP,
  output logic [NumCh*Width-1:0] UP_Q,
  output logic [NumCh-1:0]       UP_Q_VALID,
  input  logic [NumCh-1:0]       UP_Q_BP
);
  localparam int CntMax = DrainTimeout > RstCycles ? DrainTimeout : RstCycles;
  localparam int CW = clog2(CntMax + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(DrainTimeout - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RstCycles - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d, all_idle, iso, force_bp;
  logic [2*NumCh-1:0] idle;
  genvar i;
  for (i = 0; i < NumCh; i++) begin : g_mon
    stream_idle_mon #(.IdleCycles(IdleCycles)) u_up (
      .CLK(CLK), .RST(RST), .VALID(UP_D_VALID[i]), .IDLE(idle[i])
    );
    stream_idle_mon #(.IdleCycles(IdleCycles)) u_dn (
      .CLK(CLK), .RST(RST), .VALID(DN_Q_VALID[i]), .IDLE(idle[NumCh+i])
    );
  end
  assign all_idle = &idle;
  // next state; an abort wins in DRAIN, and all-idle wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    to_d = to_q;
    case (state_q)
      RUN: if (FREEZE_REQ) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      DRAIN: if (!FREEZE_REQ) state_d = RUN;
      else if (all_idle) state_d = FROZEN;
      else if (cnt_q == TO_LAST) begin
        state_d = FROZEN;
        to_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      FROZEN: if (!FREEZE_REQ) begin
        state_d = RELEASE;
        cnt_d = '0;
      end
      RELEASE: if (cnt_q == RST_LAST) state_d = RUN;
      else cnt_d = cnt_q + 1'b1;
      default: state_d = RUN;
    endcase
  end
  // state, shared counter and sticky timeout flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign iso = state_q == FROZEN || state_q == RELEASE;
  assign force_bp = iso || state_q == DRAIN;
  assign FREEZE_ACK = state_q == FROZEN;
  assign PE_RST = iso;
  assign DRAIN_TIMEOUT = to_q;
  assign DN_D = iso ? '0 : UP_D;
  assign DN_D_VALID = iso ? '0 : UP_D_VALID;
  assign UP_D_BP = force_bp ? '1 : DN_D_BP;
  assign UP_Q = iso ? '0 : DN_Q;
  assign UP_Q_VALID = iso ? '0 : DN_Q_VALID;
  assign DN_Q_BP = force_bp ? '1 : UP_Q_BP;
endmodule

// File: tb/tb_pr_decoupler.sv
// tb_pr_decoupler: directed checks of drain, freeze, timeout, release, abort and reset
module tb_pr_decoupler;
  logic CLK = 0, RST = 1, FREEZE_REQ = 0;
  logic FREEZE_ACK, PE_RST, DRAIN_TIMEOUT;
  logic [127:0] UP_D = '0, DN_Q = '0, DN_D, UP_Q;
  logic [1:0] UP_D_VALID = '0, DN_Q_VALID = '0, DN_D_BP = 2'b10, UP_Q_BP = 2'b01;
  logic [1:0] UP_D_BP, DN_D_VALID, DN_Q_BP, UP_Q_VALID;
  int checks = 0, failures = 0;
  int n, rx;
  logic ack_seen, rst_seen;

  pr_decoupler #(.NumCh(2), .Width(64), .IdleCycles(4), .DrainTimeout(64), .RstCycles(16)) dut (
    .CLK(CLK), .RST(RST), .FREEZE_REQ(FREEZE_REQ), .FREEZE_ACK(FREEZE_ACK), .PE_RST(PE_RST),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .UP_D(UP_D), .UP_D_VALID(UP_D_VALID), .UP_D_BP(UP_D_BP),
    .DN_D(DN_D), .DN_D_VALID(DN_D_VALID), .DN_D_BP(DN_D_BP), .DN_Q(DN_Q), .DN_Q_VALID(DN_Q_VALID),
    .DN_Q_BP(DN_Q_BP), .UP_Q(UP_Q), .UP_Q_VALID(UP_Q_VALID), .UP_Q_BP(UP_Q_BP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_wait();
    UP_D_VALID = '0;
    DN_Q_VALID = '0;
    repeat (6) tick();
  endtask

  task automatic wait_run(input string tag);
    n = 0;
    while (PE_RST && n < 50) begin
      n++;
      tick();
    end
    chk(tag, {63'd0, PE_RST}, 64'd0);
  endtask

  initial begin
    repeat (2) tick();
    RST = 0;
    chk("rst_ack", {63'd0, FREEZE_ACK}, 64'd0);
    chk("rst_pe_rst", {63'd0, PE_RST}, 64'd0);
    chk("rst_timeout", {63'd0, DRAIN_TIMEOUT}, 64'd0);
    UP_D = {64'hA1A1_0000_0000_0002, 64'hA0A0_0000_0000_0001};
    DN_Q = {64'hB1B1_0000_0000_0004, 64'hB0B0_0000_0000_0003};
    UP_D_VALID = 2'b11;
    DN_Q_VALID = 2'b01;
    #1;
    chk("pt_dn_d0", DN_D[63:0], 64'hA0A0_0000_0000_0001);
    chk("pt_dn_d1", DN_D[127:64], 64'hA1A1_0000_0000_0002);
    chk("pt_dn_valid", {62'd0, DN_D_VALID}, 64'd3);
    chk("pt_up_q1", UP_Q[127:64], 64'hB1B1_0000_0000_0004);
    chk("pt_up_valid", {62'd0, UP_Q_VALID}, 64'd1);
    chk("pt_up_d_bp", {62'd0, UP_D_BP}, 64'd2);
    chk("pt_dn_q_bp", {62'd0, DN_Q_BP}, 64'd1);

    idle_wait();
    FREEZE_REQ = 1;
    tick();
    chk("if_drain_ack", {63'd0, FREEZE_ACK}, 64'd0);
    chk("if_drain_bp", {62'd0, UP_D_BP}, 64'd3);
    tick();
    chk("if_ack", {63'd0, FREEZE_ACK}, 64'd1);
    chk("if_pe_rst", {63'd0, PE_RST}, 64'd1);
    UP_D_VALID = 2'b11;
    DN_Q_VALID = 2'b11;
    #1;
    chk("if_dn_valid", {62'd0, DN_D_VALID}, 64'd0);
    chk("if_up_valid", {62'd0, UP_Q_VALID}, 64'd0);
    chk("if_dn_data", DN_D[127:64] | DN_D[63:0], 64'd0);
    chk("if_up_data", UP_Q[127:64] | UP_Q[63:0], 64'd0);
    chk("if_dn_q_bp", {62'd0, DN_Q_BP}, 64'd3);
    UP_D_VALID = '0;
    DN_Q_VALID = '0;
    FREEZE_REQ = 0;
    tick();
    chk("rel_ack", {63'd0, FREEZE_ACK}, 64'd0);
    n = 0;
    while (PE_RST && n < 40) begin
      n++;
      DN_Q_VALID = 2'($urandom);
      #1;
      chk("rel_up_valid", {62'd0, UP_Q_VALID}, 64'd0);
      tick();
    end
    chk("rel_len", 64'(n), 64'd16);
    DN_Q_VALID = 2'b01;
    #1;
    chk("rel_resume", {62'd0, UP_Q_VALID}, 64'd1);

    idle_wait();
    rx = 0;
    for (int k = 0; k < 20; k++) begin
      DN_Q[127:64] = 64'(k + 100);
      DN_Q_VALID = 2'b10;
      #1;
      if (UP_Q_VALID[1] && UP_Q[127:64] == 64'(k + 100)) rx++;
      if (k == 2) chk("dr_bp", {62'd0, DN_Q_BP}, 64'd3);
      tick();
      if (k == 0) FREEZE_REQ = 1;
    end
    DN_Q_VALID = '0;
    n = 0;
    while (!FREEZE_ACK && n < 40) begin
      n++;
      tick();
    end
    chk("dr_flits", 64'(rx), 64'd20);
    chk("dr_ack_lat", 64'(n), 64'd5);
    chk("dr_no_timeout", {63'd0, DRAIN_TIMEOUT}, 64'd0);
    FREEZE_REQ = 0;
    wait_run("dr_release");

    idle_wait();
    rx = 0;
    ack_seen = 0;
    rst_seen = 0;
    for (int k = 0; k < 10; k++) begin
      UP_D[63:0] = 64'(k + 200);
      UP_D_VALID = 2'b01;
      FREEZE_REQ = k >= 2 && k <= 4;
      #1;
      if (DN_D_VALID[0] && DN_D[63:0] == 64'(k + 200)) rx++;
      ack_seen |= FREEZE_ACK;
      rst_seen |= PE_RST;
      tick();
    end
    UP_D_VALID = '0;
    chk("ab_flits", 64'(rx), 64'd10);
    chk("ab_ack", {63'd0, ack_seen}, 64'd0);
    chk("ab_pe_rst", {63'd0, rst_seen}, 64'd0);
    chk("ab_bp_pass", {62'd0, UP_D_BP}, 64'd2);

    idle_wait();
    DN_Q_VALID = 2'b01;
    FREEZE_REQ = 1;
    tick();
    n = 0;
    while (!FREEZE_ACK && n < 200) begin
      n++;
      tick();
    end
    chk("to_len", 64'(n), 64'd64);
    chk("to_flag", {63'd0, DRAIN_TIMEOUT}, 64'd1);
    chk("to_up_valid", {62'd0, UP_Q_VALID}, 64'd0);
    FREEZE_REQ = 0;
    wait_run("to_release");
    chk("to_sticky", {63'd0, DRAIN_TIMEOUT}, 64'd1);

    idle_wait();
    FREEZE_REQ = 1;
    tick();
    tick();
    chk("mr_ack", {63'd0, FREEZE_ACK}, 64'd1);
    RST = 1;
    tick();
    RST = 0;
    chk("mr_ack0", {63'd0, FREEZE_ACK}, 64'd0);
    chk("mr_pe_rst0", {63'd0, PE_RST}, 64'd0);
    chk("mr_timeout0", {63'd0, DRAIN_TIMEOUT}, 64'd0);
    chk("mr_bp_pass", {62'd0, DN_Q_BP}, 64'd1);
    FREEZE_REQ = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pr_decoupler.md
# pr_decoupler

Multi-channel partial-reconfiguration decoupler placed between the router and a reconfigurable PE. It generalises freeze-time valid masking to a parametrised number of channels and widths. It drains in-flight packets before granting a freeze, isolates both stream directions while the region is reconfigured, and sequences a PE reset on release. A drain timeout forces isolation if the PE never goes idle.

## Interface
Parameters:
- `NumCh`, 2: number of bidirectional stream channels.
- `Width`, 64: data bits per channel.
- `IdleCycles`, 4: consecutive VALID-low cycles that mark a direction as idle (packet boundary).
- `DrainTimeout`, 4096: maximum cycles spent in DRAIN before forced isolation.
- `RstCycles`, 16: PE reset pulse length on release.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `FREEZE_REQ` in 1: level request from the PR controller.
- `FREEZE_ACK` out 1: high only in FROZEN.
- `PE_RST` out 1: reset to the PE region.
- `DRAIN_TIMEOUT` out 1: sticky flag, cleared by RST only.
- `UP_D`, `UP_D_VALID`, `UP_D_BP` in, in, out; widths NumCh*Width, NumCh, NumCh: router→decoupler.
- `DN_D`, `DN_D_VALID`, `DN_D_BP` out, out, in; widths NumCh*Width, NumCh, NumCh: decoupler→PE.
- `DN_Q`, `DN_Q_VALID`, `DN_Q_BP` in, in, out; widths NumCh*Width, NumCh, NumCh: PE→decoupler.
- `UP_Q`, `UP_Q_VALID`, `UP_Q_BP` out, out, in; widths NumCh*Width, NumCh, NumCh: decoupler→router.

## Operation
- Framing: a packet is a contiguous VALID run. A flit transfers whenever VALID=1. BP is advisory, and senders stop at packet boundaries.
- Per channel and direction, a saturating idle counter (width clog2(IdleCycles+1)) increments on VALID=0 and clears on VALID=1. A direction is idle when its counter equals IdleCycles.
- FSM states: RUN → DRAIN → FROZEN → RELEASE → RUN.
- RUN: all data, VALID and BP pass through. On FREEZE_REQ=1, go to DRAIN and clear the timeout counter.
- DRAIN:
  - UP_D_BP and DN_Q_BP are forced to 1 on all channels. Data and VALID still pass, so open packets complete.
  - When every direction of every channel is idle, go to FROZEN.
  - When the timeout counter reaches DrainTimeout−1, go to FROZEN and set DRAIN_TIMEOUT.
  - If FREEZE_REQ drops while in DRAIN, go to RUN; no reset is issued.
- FROZEN:
  - DN_D_VALID=0 and UP_Q_VALID=0.
  - UP_D_BP=1 and DN_Q_BP=1.
  - DN_D and UP_Q are driven to zero.
  - PE_RST=1 and FREEZE_ACK=1.
  - On FREEZE_REQ=0, go to RELEASE.
- RELEASE:
  - Isolation is held and PE_RST=1 for RstCycles cycles, counted by the shared counter.
  - Then go to RUN; PE_RST deasserts on entering RUN.
  - FREEZE_REQ=1 during RELEASE is ignored until RUN, then handled normally.
- RST: state RUN, counters 0, DRAIN_TIMEOUT=0.

## Timing
- Datapath is combinational pass-through (0-cycle latency). Masks and forced BP are decoded from registered state only, so they change one cycle after the triggering input.
- Reset values:
  - FREEZE_ACK=0, PE_RST=0, DRAIN_TIMEOUT=0.
  - Forced BP is inactive, so UP_D_BP = DN_D_BP and DN_Q_BP = UP_Q_BP pass through.
  - Outputs otherwise follow their inputs.
- FREEZE_ACK rises exactly one cycle after the last direction reaches idle, or after timeout expiry.
- Minimum freeze latency is 1 cycle (request registered) plus 1 cycle, when all directions are already idle at request time.
- A timeout and a simultaneous all-idle condition count as idle: DRAIN_TIMEOUT is not set.
- Forced isolation truncates packets. Downstream recovery is the router's responsibility, and the flag records the event.

## Structure
- A shared package (openfc_pkg) holds the FSM state enum (RUN, DRAIN, FROZEN, RELEASE) and the function clog2.
- Sub-module `stream_idle_mon`, instantiated 2*NumCh times: inputs VALID, CLK, RST; output IDLE; parameter IdleCycles.
- The top of this block holds the FSM, the shared timeout/reset counter (width clog2(max(DrainTimeout,RstCycles)+1)) and the gating muxes.

## Test plan
- Idle freeze: NumCh=2, no traffic, FREEZE_REQ=1 at cycle 10 → FREEZE_ACK=1 at cycle 12, all outbound VALID=0.
- Drain: 20-flit packet on channel 1 DN_Q starting one cycle before FREEZE_REQ → all 20 flits appear on UP_Q. DN_Q_BP=1 from the cycle after the request. FREEZE_ACK rises IdleCycles+1 cycles after the last flit.
- Timeout: DrainTimeout=64, PE holds DN_Q_VALID[0]=1 forever → FROZEN after 64 DRAIN cycles, DRAIN_TIMEOUT=1 and stays 1. UP_Q_VALID[0]=0.
- Release: drop FREEZE_REQ in FROZEN → PE_RST high for exactly RstCycles=16 cycles after FREEZE_ACK falls, then pass-through resumes. Injected random DN_Q_VALID during RELEASE never reaches UP_Q.
- Abort: FREEZE_REQ pulse 3 cycles long during a busy packet → return to RUN, no PE_RST, FREEZE_ACK never asserted, no flit lost.
- Reset mid-FROZEN: RST=1 for 1 cycle → next cycle RUN, FREEZE_ACK=0, PE_RST=0, DRAIN_TIMEOUT=0.
